alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Sequential, parametrised successor to the combinational N-bit ALU.
//   - Keeps the 16 legacy ALUControl codes (1-cycle, registered).
//   - Adds multi-cycle shifts and an optional shift-add multiply.
//   - Valid/ready handshake on both sides; registered NZCV flag register.
//   - Sits between the datapath operand registers and writeback/condition logic.
// PARAMETERS
//   N   8            operand/result width; power of 2, N>=4
//   SW  $clog2(N)    shift-amount width (derived, not overridden)
// PORTS
//   clk        in   1   single clock, rising edge
//   reset_n    in   1   asynchronous, active-low reset
//   in_valid   in   1   operation offered
//   in_ready   out  1   block can accept; comb: IDLE, or DONE && out_ready
//   a, b       in   N   operands
//   op         in   5   op[4]=0: op[3:0]=legacy ALUControl; op[4]=1: extended op
//   flag_we    in   1   update flag register when this result is consumed
//   out_valid  out  1   result held and valid
//   out_ready  in   1   consumer accepts result
//   result     out  N   operation result
//   out_flags  out  4   {V,N,Z,C} of this result
//   out_err    out  1   reserved/disabled op code was issued
//   flags      out  4   architectural {V,N,Z,C} register
// BEHAVIOUR
//   Accept on in_valid && in_ready: latch a, b, op and flag_we.
//   FSM states:
//     IDLE -> BUSY (multi-step op), or -> DONE (single-step op).
//     BUSY -> DONE when the step counter reaches 0.
//     DONE -> IDLE on out_ready; DONE -> BUSY/DONE if a new op is accepted on the same edge.
//   Legacy ops (op[4]=0):
//     - y = {00:0, 01:b, 10:~b, 11:all-ones} selected by op[2:1]; cin = op[0].
//     - 0xxx: sum = a + y + cin.
//     - 100x AND, 101x OR, 110x XOR, 111x NOT a.
//     - C = carry out; V = (a[N-1]==y[N-1]) && (sum[N-1]!=a[N-1]).
//     - Logic ops: C = V = 0.
//     - Latency: accepted at edge k -> out_valid from cycle k+1.
//   Extended ops:
//     - 10000 MUL: low N bits of unsigned a*b. C = (high half != 0).
//     - 10001 MULH: high N bits of unsigned a*b. C = 0.
//     - 10010 LSL, 10011 LSR, 10100 ASR: shift amount s = b[SW-1:0].
//       One bit per BUSY cycle. C = last bit shifted out (0 when s=0). V = 0.
//       s=0 -> out_valid at k+1; otherwise out_valid at k+1+s.
//     - MUL/MULH: N shift-add steps -> out_valid at k+1+N. V = 0.
//     - 10101..11111 (reserved): result = 0, out_err = 1, Z = 1, out_valid at k+1.
//   All ops: N = result[N-1]; Z = (result == 0).
//   result, out_flags and out_err:
//     - Stable while out_valid && !out_ready.
//     - Change only on a new completion.
//   flags register:
//     - Loaded with out_flags on the out_valid && out_ready edge, if the latched flag_we = 1.
//     - Otherwise it holds its value.
//   in_ready = 0 in BUSY and in DONE with !out_ready; no op is dropped.
//   Consume and accept on the same edge:
//     - A 1-cycle op gives back-to-back out_valid.
//     - The flags update from the old result occurs on that edge.
//   Reset (async, any state, including mid-BUSY): state IDLE, out_valid = 0,
//     result = 0, out_flags = 0, out_err = 0, flags = 0. The partial op is discarded.
// CONFIGURATION
//   ALU_SEQ_MUL_EN defined:
//     - MUL/MULH implemented as above (N-step shift-add, 2N-bit accumulator).
//   ALU_SEQ_MUL_EN undefined:
//     - 10000/10001 are reserved: result = 0, out_err = 1, 1-cycle latency.
//     - No multiplier hardware is built.
// TESTING (N=8)
//   1. ADD op=00010, a=7F, b=01, flag_we=1 -> result 80, out_flags 1100,
//      out_valid at k+1; flags = 1100 after handshake.
//   2. SUB op=00101, a=05, b=05, flag_we=0 -> result 00, out_flags 0011;
//      flags unchanged (1100).
//   3. LSL op=10010, a=A1, b=03 -> result 08, C=1, out_valid at k+4.
//      ASR op=10100, a=90, b=02 -> result E4, out_flags 0100.
//   4. MUL a=10, b=10 with ALU_SEQ_MUL_EN -> result 00, Z=1, C=1 at k+9;
//      MULH on the same operands -> result 01.
//      Without ALU_SEQ_MUL_EN -> out_err=1, result 00 at k+1.
//   5. Hold out_ready=0 for 5 cycles after ADD done:
//      - result and flags stay stable; in_ready=0.
//      - Then out_ready=1 with a new in_valid -> accepted the same edge.
//   6. Assert reset_n=0 in cycle 3 of an LSL by 7:
//      - All outputs = 0 and state IDLE immediately.
//      - After release, ADD 01+01 -> 02.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential N-bit ALU. It runs the legacy ALUControl ops in one cycle and shifts one bit per cycle.
// Define ALU_SEQ_MUL_EN to build the N-step shift-add MUL/MULH; otherwise those codes are reserved.
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [4:0]   op,
  input  logic         flag_we,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   out_flags,
  output logic         out_err,
  output logic [3:0]   flags
);
  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;

  logic [2:0]    kind_r;
  logic          fwe_r;
  logic [N-1:0]  w, w_next, fin_res;
  logic          fin_c;
  logic [CW-1:0] cnt;
  logic [N:0]    step;
  logic [SW-1:0] s_in;
  logic          accept, is_shift_in, is_mul_in, multi_in;
  logic [N+1:0]  leg;
  logic [N-1:0]  one_res;
  logic [3:0]    one_flags;
  logic          one_err;
`ifdef ALU_SEQ_MUL_EN
  logic [N-1:0]  mcand, hi, hi_next;
  logic [N:0]    msum;
`endif

  function automatic logic [3:0] pack_flags(input logic v, input logic [N-1:0] r, input logic c);
    return {v, r[N-1], (r == '0), c};
  endfunction

  // Returns {V, C, result} for the 16 legacy ALUControl codes.
  function automatic logic [N+1:0] legacy_op(input logic [3:0] code, input logic [N-1:0] x,
                                             input logic [N-1:0] yb);
    logic [N-1:0] y;
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         v, c;
    case (code[2:1])
      2'b00:   y = '0;
      2'b01:   y = yb;
      2'b10:   y = ~yb;
      default: y = '1;
    endcase
    s = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, code[0]};
    if (!code[3]) begin
      r = s[N-1:0];
      c = s[N];
      v = (x[N-1] == y[N-1]) && (s[N-1] != x[N-1]);
    end else begin
      c = 1'b0;
      v = 1'b0;
      case (code[2:1])
        2'b00:   r = x & yb;
        2'b01:   r = x | yb;
        2'b10:   r = x ^ yb;
        default: r = ~x;
      endcase
    end
    return {v, c, r};
  endfunction

  // One-bit shift step; returns {bit shifted out, shifted value}.
  function automatic logic [N:0] shift_step(input logic [2:0] kind, input logic [N-1:0] x);
    logic signed [N-1:0] xs;
    xs = x;
    case (kind)
      3'b010:  return {x[N-1], x[N-2:0], 1'b0};
      3'b011:  return {x[0], 1'b0, x[N-1:1]};
      default: return {x[0], xs >>> 1};
    endcase
  endfunction

  assign s_in        = b[SW-1:0];
  assign is_shift_in = op[4] && (op[3:0] inside {4'h2, 4'h3, 4'h4});
`ifdef ALU_SEQ_MUL_EN
  assign is_mul_in   = op[4] && (op[3:1] == 3'b000);
`else
  assign is_mul_in   = 1'b0;
`endif
  assign multi_in    = (is_shift_in && (s_in != '0)) || is_mul_in;
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state == DONE);
  assign leg         = legacy_op(op[3:0], a, b);

  always_comb begin
    one_res   = '0;
    one_flags = pack_flags(1'b0, '0, 1'b0);
    one_err   = 1'b1;
    if (!op[4]) begin
      one_res   = leg[N-1:0];
      one_flags = pack_flags(leg[N+1], leg[N-1:0], leg[N]);
      one_err   = 1'b0;
    end else if (is_shift_in) begin
      one_res   = a;
      one_flags = pack_flags(1'b0, a, 1'b0);
      one_err   = 1'b0;
    end
  end

  always_comb begin
    step    = shift_step(kind_r, w);
    w_next  = step[N-1:0];
    fin_res = step[N-1:0];
    fin_c   = step[N];
`ifdef ALU_SEQ_MUL_EN
    // {hi, w} is the 2N-bit product accumulator; w starts as the multiplier.
    msum    = {1'b0, hi} + (w[0] ? {1'b0, mcand} : {(N+1){1'b0}});
    hi_next = msum[N:1];
    if (kind_r[2:1] == 2'b00) begin
      w_next  = {msum[0], w[N-1:1]};
      fin_res = kind_r[0] ? hi_next : w_next;
      fin_c   = kind_r[0] ? 1'b0 : (hi_next != '0);
    end
`endif
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = multi_in ? BUSY : DONE;
      end
      BUSY: if (cnt == CW'(1)) state_next = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? (multi_in ? BUSY : DONE) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      out_flags <= '0;
      out_err   <= 1'b0;
      flags     <= '0;
      cnt       <= '0;
    end else begin
      // Flags commit from the result being consumed, even if a new op is accepted this edge.
      if (out_valid && out_ready && fwe_r) flags <= out_flags;
      if (accept) begin
        cnt <= is_mul_in ? CW'(N) : CW'(s_in);
        if (!multi_in) begin
          result    <= one_res;
          out_flags <= one_flags;
          out_err   <= one_err;
        end
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          result    <= fin_res;
          out_flags <= pack_flags(1'b0, fin_res, fin_c);
          out_err   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      kind_r <= op[2:0];
      fwe_r  <= flag_we;
      w      <= is_mul_in ? b : a;
`ifdef ALU_SEQ_MUL_EN
      mcand  <= a;
      hi     <= '0;
`endif
    end else if (state == BUSY) begin
      w      <= w_next;
`ifdef ALU_SEQ_MUL_EN
      hi     <= hi_next;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (N=8); the MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, flag_we, out_valid, out_ready, out_err;
  logic [7:0] a, b, result;
  logic [4:0] op;
  logic [3:0] out_flags, flags;
  int         cmp_cnt = 0;
  int         err_cnt = 0;

  alu_seq #(.N(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .flag_we(flag_we), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_flags(out_flags),
    .out_err(out_err), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic fw);
    op = o; a = x; b = y; flag_we = fw; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flag_we = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    cmp_cnt++; if (result !== 8'h00) begin err_cnt++; $display("FAIL reset_result: got %h want 00", result); end
    cmp_cnt++; if (out_flags !== 4'b0000 || out_err !== 1'b0) begin err_cnt++; $display("FAIL reset_out_flags_err: got %b/%b want 0000/0", out_flags, out_err); end
    cmp_cnt++; if (flags !== 4'b0000) begin err_cnt++; $display("FAIL reset_flags: got %b want 0000", flags); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    int n;
    start_op(5'b00010, 8'h7F, 8'h01, 1'b1);
    wait_done(n);
    cmp_cnt++; if (n !== 0) begin err_cnt++; $display("FAIL add_latency: got %0d want 0 extra cycles", n); end
    cmp_cnt++; if (result !== 8'h80) begin err_cnt++; $display("FAIL add_result: got %h want 80", result); end
    cmp_cnt++; if (out_flags !== 4'b1100) begin err_cnt++; $display("FAIL add_out_flags: got %b want 1100", out_flags); end
    consume();
    cmp_cnt++; if (flags !== 4'b1100) begin err_cnt++; $display("FAIL add_flags: got %b want 1100", flags); end
    cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL add_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_sub();
    int n;
    start_op(5'b00101, 8'h05, 8'h05, 1'b0);
    wait_done(n);
    cmp_cnt++; if (result !== 8'h00) begin err_cnt++; $display("FAIL sub_result: got %h want 00", result); end
    cmp_cnt++; if (out_flags !== 4'b0011) begin err_cnt++; $display("FAIL sub_out_flags: got %b want 0011", out_flags); end
    consume();
    cmp_cnt++; if (flags !== 4'b1100) begin err_cnt++; $display("FAIL sub_flags_held: got %b want 1100", flags); end
  endtask

  task automatic test_legacy();
    logic [4:0] ov [8] = '{5'b01000, 5'b01010, 5'b01100, 5'b01110, 5'b00011, 5'b00110, 5'b00111, 5'b00001};
    logic [7:0] av [8] = '{8'hCA, 8'hCA, 8'hCA, 8'hCA, 8'hFF, 8'h80, 8'h00, 8'hFF};
    logic [7:0] bv [8] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h01, 8'h00, 8'h5A, 8'h33};
    logic [7:0] rv [8] = '{8'h0A, 8'hCF, 8'hC5, 8'h35, 8'h01, 8'h7F, 8'h00, 8'h00};
    logic [3:0] fv [8] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b1001, 4'b0011, 4'b0011};
    int n;
    for (int i = 0; i < 8; i++) begin
      start_op(ov[i], av[i], bv[i], 1'b0);
      wait_done(n);
      cmp_cnt++; if (n !== 0 || result !== rv[i]) begin err_cnt++; $display("FAIL legacy_result[%0d]: got %h after %0d want %h after 0", i, result, n, rv[i]); end
      cmp_cnt++; if (out_flags !== fv[i]) begin err_cnt++; $display("FAIL legacy_flags[%0d]: got %b want %b", i, out_flags, fv[i]); end
      consume();
    end
  endtask

  task automatic test_shift();
    logic [4:0] ov [4] = '{5'b10010, 5'b10100, 5'b10011, 5'b10010};
    logic [7:0] av [4] = '{8'hA1, 8'h90, 8'h81, 8'h55};
    logic [7:0] bv [4] = '{8'h03, 8'h02, 8'h01, 8'h08};
    logic [7:0] rv [4] = '{8'h08, 8'hE4, 8'h40, 8'h55};
    logic [3:0] fv [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0000};
    int         lv [4] = '{3, 2, 1, 0};
    int n;
    for (int i = 0; i < 4; i++) begin
      start_op(ov[i], av[i], bv[i], 1'b0);
      cmp_cnt++; if (lv[i] > 0 && in_ready !== 1'b0) begin err_cnt++; $display("FAIL shift_busy_ready[%0d]: got %b want 0", i, in_ready); end
      wait_done(n);
      cmp_cnt++; if (n !== lv[i]) begin err_cnt++; $display("FAIL shift_latency[%0d]: got %0d want %0d", i, n, lv[i]); end
      cmp_cnt++; if (result !== rv[i] || out_flags !== fv[i]) begin err_cnt++; $display("FAIL shift_value[%0d]: got %h/%b want %h/%b", i, result, out_flags, rv[i], fv[i]); end
      consume();
    end
  endtask

  task automatic test_mul();
    int n;
    start_op(5'b10000, 8'h10, 8'h10, 1'b0);
    wait_done(n);
`ifdef ALU_SEQ_MUL_EN
    cmp_cnt++; if (n !== 8) begin err_cnt++; $display("FAIL mul_latency: got %0d want 8", n); end
    cmp_cnt++; if (result !== 8'h00 || out_flags !== 4'b0011 || out_err !== 1'b0) begin err_cnt++; $display("FAIL mul_value: got %h/%b/%b want 00/0011/0", result, out_flags, out_err); end
    consume();
    start_op(5'b10001, 8'h10, 8'h10, 1'b0);
    wait_done(n);
    cmp_cnt++; if (result !== 8'h01 || out_flags !== 4'b0000) begin err_cnt++; $display("FAIL mulh_value: got %h/%b want 01/0000", result, out_flags); end
    consume();
    start_op(5'b10000, 8'h0D, 8'h0B, 1'b0);
    wait_done(n);
    cmp_cnt++; if (result !== 8'h8F || out_flags !== 4'b0100) begin err_cnt++; $display("FAIL mul_small: got %h/%b want 8F/0100", result, out_flags); end
`else
    cmp_cnt++; if (n !== 0) begin err_cnt++; $display("FAIL mul_off_latency: got %0d want 0", n); end
    cmp_cnt++; if (result !== 8'h00 || out_err !== 1'b1 || out_flags !== 4'b0010) begin err_cnt++; $display("FAIL mul_off_value: got %h/%b/%b want 00/0010/1", result, out_flags, out_err); end
`endif
    consume();
    start_op(5'b10111, 8'hFF, 8'hFF, 1'b0);
    wait_done(n);
    cmp_cnt++; if (n !== 0 || result !== 8'h00 || out_err !== 1'b1 || out_flags !== 4'b0010) begin err_cnt++; $display("FAIL reserved: got %h/%b/%b after %0d want 00/0010/1 after 0", result, out_flags, out_err, n); end
    consume();
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(5'b00010, 8'h01, 8'h01, 1'b1);
    wait_done(n);
    cmp_cnt++; if (result !== 8'h02 || out_err !== 1'b0) begin err_cnt++; $display("FAIL stall_first: got %h/%b want 02/0", result, out_err); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmp_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h02 || out_flags !== 4'b0000 || flags !== 4'b1100) begin
        err_cnt++; $display("FAIL stall_hold[%0d]: got v=%b rdy=%b %h/%b/%b want 1/0 02/0000/1100", i, out_valid, in_ready, result, out_flags, flags);
      end
    end
    op = 5'b00101; a = 8'h05; b = 8'h05; flag_we = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    cmp_cnt++; if (flags !== 4'b0000) begin err_cnt++; $display("FAIL b2b_old_flags: got %b want 0000", flags); end
    cmp_cnt++; if (out_valid !== 1'b1 || result !== 8'h00 || out_flags !== 4'b0011) begin err_cnt++; $display("FAIL b2b_next: got v=%b %h/%b want 1 00/0011", out_valid, result, out_flags); end
    consume();
    cmp_cnt++; if (flags !== 4'b0011) begin err_cnt++; $display("FAIL b2b_new_flags: got %b want 0011", flags); end
  endtask

  task automatic test_reset_mid();
    int n;
    start_op(5'b10010, 8'hFF, 8'h07, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    cmp_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL midreset_state: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    cmp_cnt++; if (result !== 8'h00 || out_flags !== 4'b0000 || out_err !== 1'b0 || flags !== 4'b0000) begin
      err_cnt++; $display("FAIL midreset_outputs: got %h/%b/%b/%b want 00/0000/0/0000", result, out_flags, out_err, flags);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    start_op(5'b00010, 8'h01, 8'h01, 1'b0);
    wait_done(n);
    cmp_cnt++; if (n !== 0 || result !== 8'h02) begin err_cnt++; $display("FAIL post_reset_add: got %h after %0d want 02 after 0", result, n); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_legacy();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
